// File: rtl/wb_fabric_pkg.sv
// Shared types and defaults for the single-master Wishbone fabric.
// Holds the FSM state encoding, timer width and the default two-slave address map.
package wb_fabric_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ERR    = 2'd2
    } fabric_state_e;

    localparam int timer_width = 16;

    // Slave 1 = 16-byte UART window at 0x8000_0000, slave 0 = 64 KiB memory at 0x0.
    localparam logic [63:0] default_base = {32'h8000_0000, 32'h0000_0000};
    localparam logic [63:0] default_mask = {32'hFFFF_FFF0, 32'hFFFF_0000};

    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_fabric_decode.sv
// Combinational address decoder: base/mask compare per slave, lowest matching index wins.
module wb_fabric_decode
    import wb_fabric_pkg::*;
#(
    parameter int addr_width  = 32,
    parameter int slave_count = 2,
    parameter logic [slave_count*addr_width-1:0] slave_base = default_base,
    parameter logic [slave_count*addr_width-1:0] slave_mask = default_mask,
    localparam int idx_width = idx_bits(slave_count)
) (
    input  logic [addr_width-1:0] adr,
    output logic                  hit,
    output logic [idx_width-1:0]  idx
);

    // Scanning from the top down lets the lowest overlapping index overwrite the result last.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = slave_count - 1; i >= 0; i--) begin
            if ((adr & slave_mask[i*addr_width +: addr_width]) == slave_base[i*addr_width +: addr_width]) begin
                hit = 1'b1;
                idx = idx_width'(i);
            end
        end
    end

endmodule

// File: rtl/wb_fabric.sv
// Single-master to N-slave Wishbone classic fabric with decode-miss error termination.
// Define WB_FABRIC_TIMEOUT_EN to also terminate hung slaves with wb_err after timeout_cycles.
module wb_fabric
    import wb_fabric_pkg::*;
#(
    parameter int addr_width     = 32,
    parameter int data_width     = 32,
    parameter int slave_count    = 2,
    parameter logic [slave_count*addr_width-1:0] slave_base = default_base,
    parameter logic [slave_count*addr_width-1:0] slave_mask = default_mask,
    parameter int timeout_cycles = 255,
    localparam int strobe_width  = data_width / 8,
    localparam int idx_width     = idx_bits(slave_count)
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [addr_width-1:0]             wb_adr,
    input  logic [data_width-1:0]             wb_datwr,
    input  logic                              wb_we,
    input  logic [strobe_width-1:0]           wb_sel,
    input  logic                              wb_stb,
    input  logic                              wb_cyc,
    output logic [data_width-1:0]             wb_datrd,
    output logic                              wb_ack,
    output logic                              wb_err,
    output logic [addr_width-1:0]             s_adr,
    output logic [data_width-1:0]             s_datwr,
    output logic                              s_we,
    output logic [strobe_width-1:0]           s_sel,
    output logic [slave_count-1:0]            s_stb,
    output logic [slave_count-1:0]            s_cyc,
    input  logic [slave_count*data_width-1:0] s_datrd,
    input  logic [slave_count-1:0]            s_ack,
    output logic [1:0]                        dbg_state
);

    // Handshake: a transfer is requested while wb_cyc & wb_stb are high and ends on the
    // first cycle wb_ack or wb_err is high; dropping wb_cyc abandons it silently.

    fabric_state_e          state, state_next;
    logic [idx_width-1:0]   sel_idx, sel_next;
    logic                   dec_hit;
    logic [idx_width-1:0]   dec_idx;

    wb_fabric_decode #(
        .addr_width  (addr_width),
        .slave_count (slave_count),
        .slave_base  (slave_base),
        .slave_mask  (slave_mask)
    ) u_decode (
        .adr (wb_adr),
        .hit (dec_hit),
        .idx (dec_idx)
    );

    assign s_adr     = wb_adr;
    assign s_datwr   = wb_datwr;
    assign s_we      = wb_we;
    assign s_sel     = wb_sel;
    assign dbg_state = state;

`ifdef WB_FABRIC_TIMEOUT_EN
    localparam logic [timer_width-1:0] timer_last = timer_width'(timeout_cycles - 1);
    logic [timer_width-1:0] timer;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer <= '0;
        end else if (state != ST_ACTIVE) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            sel_idx <= '0;
        end else begin
            state   <= state_next;
            sel_idx <= sel_next;
        end
    end

    always_comb begin
        state_next = state;
        sel_next   = sel_idx;
        s_stb      = '0;
        s_cyc      = '0;
        wb_ack     = 1'b0;
        wb_err     = 1'b0;
        wb_datrd   = '0;
        case (state)
            ST_IDLE: begin
                if (wb_cyc && wb_stb) begin
                    if (dec_hit) begin
                        state_next = ST_ACTIVE;
                        sel_next   = dec_idx;
                    end else begin
                        state_next = ST_ERR;
                    end
                end
            end
            ST_ACTIVE: begin
                s_stb[sel_idx] = wb_stb;
                s_cyc[sel_idx] = wb_cyc;
                // Abort has priority: a late slave ack is not forwarded once wb_cyc is gone.
                if (!wb_cyc) begin
                    state_next = ST_IDLE;
                end else if (s_ack[sel_idx]) begin
                    wb_ack     = 1'b1;
                    wb_datrd   = s_datrd[sel_idx*data_width +: data_width];
                    state_next = ST_IDLE;
                end
`ifdef WB_FABRIC_TIMEOUT_EN
                else if (timer == timer_last) begin
                    state_next = ST_ERR;
                end
`endif
            end
            ST_ERR: begin
                wb_err     = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_fabric.sv
// Directed bench for wb_fabric: two slaves, default map, timeout_cycles = 16.
module tb_wb_fabric;

    logic        clock;
    logic        reset;
    logic [31:0] wb_adr;
    logic [31:0] wb_datwr;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic        wb_stb;
    logic        wb_cyc;
    logic [31:0] wb_datrd;
    logic        wb_ack;
    logic        wb_err;
    logic [31:0] s_adr;
    logic [31:0] s_datwr;
    logic        s_we;
    logic [3:0]  s_sel;
    logic [1:0]  s_stb;
    logic [1:0]  s_cyc;
    logic [63:0] s_datrd;
    logic [1:0]  s_ack;
    logic [1:0]  dbg_state;

    int compared   = 0;
    int mismatched = 0;
    int err_seen;

    wb_fabric #(
        .timeout_cycles (16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .wb_adr    (wb_adr),
        .wb_datwr  (wb_datwr),
        .wb_we     (wb_we),
        .wb_sel    (wb_sel),
        .wb_stb    (wb_stb),
        .wb_cyc    (wb_cyc),
        .wb_datrd  (wb_datrd),
        .wb_ack    (wb_ack),
        .wb_err    (wb_err),
        .s_adr     (s_adr),
        .s_datwr   (s_datwr),
        .s_we      (s_we),
        .s_sel     (s_sel),
        .s_stb     (s_stb),
        .s_cyc     (s_cyc),
        .s_datrd   (s_datrd),
        .s_ack     (s_ack),
        .dbg_state (dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc_begin();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    task automatic master(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                          input logic [3:0] sel, input logic cyc, input logic stb);
        wb_adr   = adr;
        wb_datwr = dat;
        wb_we    = we;
        wb_sel   = sel;
        wb_cyc   = cyc;
        wb_stb   = stb;
    endtask

    initial begin
        reset   = 1'b0;
        s_ack   = 2'b00;
        s_datrd = '0;
        master(32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0);

        // Reset state
        mid();
        check("rst_state", 32'(dbg_state), 0);
        check("rst_stb",   32'(s_stb), 0);
        check("rst_cyc",   32'(s_cyc), 0);
        check("rst_ack",   32'(wb_ack), 0);
        check("rst_err",   32'(wb_err), 0);
        check("rst_datrd", wb_datrd, 0);
        cyc_begin();
        reset = 1'b1;

        // Read 0x104 from slave0, ack two cycles after its strobe
        cyc_begin();
        master(32'h0000_0104, 32'h0, 1'b0, 4'hF, 1'b1, 1'b1);
        s_datrd = {32'h0, 32'hDEAD_BEEF};
        mid();
        check("rd_decode_stb", 32'(s_stb), 0);
        check("rd_adr_pass",   s_adr, 32'h0000_0104);
        cyc_begin();
        mid();
        check("rd_stb_a",   32'(s_stb), 1);
        check("rd_cyc_a",   32'(s_cyc), 1);
        check("rd_noack_a", 32'(wb_ack), 0);
        check("rd_datrd_gated", wb_datrd, 0);
        cyc_begin();
        mid();
        check("rd_stb_b",   32'(s_stb), 1);
        check("rd_noack_b", 32'(wb_ack), 0);
        cyc_begin();
        s_ack = 2'b01;
        mid();
        check("rd_ack",   32'(wb_ack), 1);
        check("rd_datrd", wb_datrd, 32'hDEAD_BEEF);
        check("rd_stb_c", 32'(s_stb), 1);
        cyc_begin();
        s_ack = 2'b00;
        master(32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        mid();
        check("rd_done_ack",   32'(wb_ack), 0);
        check("rd_done_state", 32'(dbg_state), 0);

        // Write 0x41 to slave1 at 0x8000_0004
        cyc_begin();
        master(32'h8000_0004, 32'h0000_0041, 1'b1, 4'b0001, 1'b1, 1'b1);
        s_datrd = {32'h0000_5555, 32'h0};
        mid();
        check("wr_datwr", s_datwr, 32'h0000_0041);
        check("wr_sel",   32'(s_sel), 1);
        check("wr_we",    32'(s_we), 1);
        check("wr_decode_stb", 32'(s_stb), 0);
        cyc_begin();
        mid();
        check("wr_stb",   32'(s_stb), 2);
        check("wr_noack", 32'(wb_ack), 0);
        cyc_begin();
        s_ack = 2'b10;
        mid();
        check("wr_ack",   32'(wb_ack), 1);
        check("wr_datrd", wb_datrd, 32'h0000_5555);
        cyc_begin();
        s_ack = 2'b00;
        master(32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        mid();
        check("wr_done_ack", 32'(wb_ack), 0);

        // Unmapped access terminates with a single-cycle error
        cyc_begin();
        master(32'h4000_0000, 32'h0, 1'b0, 4'hF, 1'b1, 1'b1);
        mid();
        check("um_err_early", 32'(wb_err), 0);
        check("um_stb_a",     32'(s_stb), 0);
        cyc_begin();
        master(32'h4000_0000, 32'h0, 1'b0, 4'hF, 1'b0, 1'b0);
        mid();
        check("um_err",   32'(wb_err), 1);
        check("um_noack", 32'(wb_ack), 0);
        check("um_stb_b", 32'(s_stb), 0);
        check("um_datrd", wb_datrd, 0);
        cyc_begin();
        mid();
        check("um_err_once", 32'(wb_err), 0);

        // Slave1 never acks
        cyc_begin();
        master(32'h8000_0008, 32'h0, 1'b0, 4'hF, 1'b1, 1'b1);
`ifdef WB_FABRIC_TIMEOUT_EN
        err_seen = 0;
        for (int i = 0; i < 16; i++) begin
            cyc_begin();
            mid();
            if (wb_err) err_seen++;
        end
        check("to_no_early_err", 32'(err_seen), 0);
        check("to_stb_held",     32'(s_stb), 2);
        cyc_begin();
        master(32'h8000_0008, 32'h0, 1'b0, 4'hF, 1'b0, 1'b0);
        mid();
        check("to_err",     32'(wb_err), 1);
        check("to_stb_low", 32'(s_stb), 0);
        check("to_noack",   32'(wb_ack), 0);
        cyc_begin();
        mid();
        check("to_err_once", 32'(wb_err), 0);
`else
        err_seen = 0;
        for (int i = 0; i < 1000; i++) begin
            cyc_begin();
            mid();
            if (wb_err) err_seen++;
        end
        check("hang_no_err",   32'(err_seen), 0);
        check("hang_stb_held", 32'(s_stb), 2);
        cyc_begin();
        master(32'h8000_0008, 32'h0, 1'b0, 4'hF, 1'b0, 1'b0);
        mid();
        check("hang_abort_cyc", 32'(s_cyc), 0);
        cyc_begin();
        mid();
        check("hang_abort_state", 32'(dbg_state), 0);
`endif

        // Abort in ACTIVE: late slave ack must not reach the master
        cyc_begin();
        master(32'h0000_0010, 32'h0, 1'b0, 4'hF, 1'b1, 1'b1);
        cyc_begin();
        mid();
        check("ab_cyc", 32'(s_cyc), 1);
        cyc_begin();
        master(32'h0000_0010, 32'h0, 1'b0, 4'hF, 1'b0, 1'b0);
        s_ack = 2'b01;
        mid();
        check("ab_noack", 32'(wb_ack), 0);
        check("ab_cyc_low", 32'(s_cyc), 0);
        cyc_begin();
        s_ack = 2'b00;
        mid();
        check("ab_state", 32'(dbg_state), 0);
        check("ab_noerr", 32'(wb_err), 0);

        // Reset pulsed mid-transfer, then the held request decodes again
        cyc_begin();
        master(32'h8000_0000, 32'h0, 1'b0, 4'hF, 1'b1, 1'b1);
        s_datrd = {32'h1234_5678, 32'h0};
        cyc_begin();
        mid();
        check("rs_stb_before", 32'(s_stb), 2);
        #1;
        reset = 1'b0;
        #1;
        check("rs_state", 32'(dbg_state), 0);
        check("rs_stb",   32'(s_stb), 0);
        check("rs_cyc",   32'(s_cyc), 0);
        check("rs_ack",   32'(wb_ack), 0);
        cyc_begin();
        reset = 1'b1;
        mid();
        check("rs_idle", 32'(dbg_state), 0);
        cyc_begin();
        s_ack = 2'b10;
        mid();
        check("rs_redecode_stb", 32'(s_stb), 2);
        check("rs_ack_after",    32'(wb_ack), 1);
        check("rs_datrd_after",  wb_datrd, 32'h1234_5678);
        cyc_begin();
        s_ack = 2'b00;
        master(32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        mid();
        check("rs_done", 32'(wb_ack), 0);

        // Stray ack from slave0 while slave1 is selected, then back-to-back to slave0
        cyc_begin();
        master(32'h8000_000C, 32'h0, 1'b0, 4'hF, 1'b1, 1'b1);
        s_datrd = {32'hCAFE_0001, 32'hBEEF_0002};
        cyc_begin();
        s_ack = 2'b01;
        mid();
        check("st_stray_ack",   32'(wb_ack), 0);
        check("st_stray_datrd", wb_datrd, 0);
        check("st_stb",         32'(s_stb), 2);
        cyc_begin();
        s_ack = 2'b10;
        mid();
        check("bb_ack1",   32'(wb_ack), 1);
        check("bb_datrd1", wb_datrd, 32'hCAFE_0001);
        cyc_begin();
        s_ack = 2'b00;
        master(32'h0000_0200, 32'h0, 1'b0, 4'hF, 1'b1, 1'b1);
        mid();
        check("bb_gap_stb", 32'(s_stb), 0);
        check("bb_gap_ack", 32'(wb_ack), 0);
        cyc_begin();
        s_ack = 2'b01;
        mid();
        check("bb_stb0",   32'(s_stb), 1);
        check("bb_ack0",   32'(wb_ack), 1);
        check("bb_datrd0", wb_datrd, 32'hBEEF_0002);
        cyc_begin();
        s_ack = 2'b00;
        master(32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        mid();
        check("bb_end_ack",   32'(wb_ack), 0);
        check("bb_end_state", 32'(dbg_state), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
